// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin bus arbiter with bounded hold under contention
module bus_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 64,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_wr,
  input  logic          m1_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m0_dout,
  input  logic [DW-1:0] m1_dout,
  input  logic [DW-1:0] bus_din,
  output logic          m0_grant,
  output logic          m1_grant,
  output logic [DW-1:0] m0_din,
  output logic [DW-1:0] m1_din,
  output logic          bus_req,
  output logic          bus_wr,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state;
  state_t     next_state;
  logic       last;
  logic       next_last;
  logic [7:0] hold_cnt;
  logic [7:0] next_hold_cnt;

  // Note: reset_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold_cnt <= 8'd0;
    end else begin
      state    <= next_state;
      last     <= next_last;
      hold_cnt <= next_hold_cnt;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) next_state = last ? GNT0 : GNT1;
        else if (m0_req)      next_state = GNT0;
        else if (m1_req)      next_state = GNT1;
      end
      GNT0: begin
        if (!m0_req)                              next_state = m1_req ? GNT1 : IDLE;
        else if (m1_req && hold_cnt == HOLD_LAST) next_state = GNT1;
      end
      GNT1: begin
        if (!m1_req)                              next_state = m0_req ? GNT0 : IDLE;
        else if (m0_req && hold_cnt == HOLD_LAST) next_state = GNT0;
      end
      default: next_state = IDLE;
    endcase
  end

  // Hold counter restarts on any change of owner and saturates so an
  // uncontested master can keep the bus indefinitely.
  always_comb begin
    next_hold_cnt = 8'd0;
    next_last     = last;
    if (next_state == GNT0) next_last = 1'b0;
    if (next_state == GNT1) next_last = 1'b1;
    if (next_state != IDLE && next_state == state) begin
      next_hold_cnt = (hold_cnt < HOLD_LAST) ? hold_cnt + 8'd1 : hold_cnt;
    end
  end

  assign m0_grant = (state == GNT0);
  assign m1_grant = (state == GNT1);

  always_comb begin
    bus_req  = 1'b0;
    bus_wr   = 1'b0;
    bus_addr = '0;
    bus_dout = '0;
    m0_din   = '0;
    m1_din   = '0;
    case (state)
      GNT0: begin
        bus_req  = m0_req;
        bus_wr   = m0_wr;
        bus_addr = m0_addr;
        bus_dout = m0_dout;
        m0_din   = bus_din;
      end
      GNT1: begin
        bus_req  = m1_req;
        bus_wr   = m1_wr;
        bus_addr = m1_addr;
        bus_dout = m1_dout;
        m1_din   = bus_din;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

  localparam int AW = 16;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          m0_req, m1_req, m0_wr, m1_wr;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_dout, m1_dout, bus_din;
  logic          m0_grant, m1_grant;
  logic [DW-1:0] m0_din, m1_din;
  logic          bus_req, bus_wr;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_dout;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m1_req(m1_req), .m0_wr(m0_wr), .m1_wr(m1_wr),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_dout(m0_dout), .m1_dout(m1_dout),
    .bus_din(bus_din), .m0_grant(m0_grant), .m1_grant(m1_grant),
    .m0_din(m0_din), .m1_din(m1_din), .bus_req(bus_req), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_dout(bus_dout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_g0"}, 64'(m0_grant), 64'd0);
    chk({tag, "_g1"}, 64'(m1_grant), 64'd0);
    chk({tag, "_breq"}, 64'(bus_req), 64'd0);
    chk({tag, "_bwr"}, 64'(bus_wr), 64'd0);
    chk({tag, "_baddr"}, 64'(bus_addr), 64'd0);
    chk({tag, "_bdout"}, bus_dout, 64'd0);
    chk({tag, "_din0"}, m0_din, 64'd0);
    chk({tag, "_din1"}, m1_din, 64'd0);
  endtask

  initial begin
    reset_n = 1'b1;
    m0_req = 0; m1_req = 0; m0_wr = 0; m1_wr = 0;
    m0_addr = 16'h0055; m1_addr = 16'h00AA;
    m0_dout = 64'h11; m1_dout = 64'h22;
    bus_din = 64'hDEAD_BEEF;
    tick();
    tick();
    chk_idle_outputs("reset");
    reset_n = 1'b0;

    // Single master 0 write
    m0_req = 1; m0_wr = 1; m0_addr = 16'h0010; m0_dout = 64'd10;
    tick();
    chk("w0_grant0", 64'(m0_grant), 64'd1);
    chk("w0_grant1", 64'(m1_grant), 64'd0);
    chk("w0_breq", 64'(bus_req), 64'd1);
    chk("w0_bwr", 64'(bus_wr), 64'd1);
    chk("w0_baddr", 64'(bus_addr), 64'h0010);
    chk("w0_bdout", bus_dout, 64'd10);
    chk("w0_din0", m0_din, 64'hDEAD_BEEF);
    chk("w0_din1", m1_din, 64'd0);
    m0_req = 0;
    #1;
    chk("drop_last_grant", 64'(m0_grant), 64'd1);
    chk("drop_last_breq", 64'(bus_req), 64'd0);
    tick();
    chk_idle_outputs("drop_idle");

    // Contention after reset: m0 first, 8 cycles each
    reset_n = 1'b1;
    tick();
    reset_n = 1'b0;
    m0_req = 1; m1_req = 1;
    tick();
    chk("tie_first_g0", 64'(m0_grant), 64'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("hold0_c%0d", i), 64'(m0_grant), 64'd1);
    end
    tick();
    chk("swap_to1_g1", 64'(m1_grant), 64'd1);
    chk("swap_to1_g0", 64'(m0_grant), 64'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("hold1_c%0d", i), 64'(m1_grant), 64'd1);
    end
    tick();
    chk("swap_to0_g0", 64'(m0_grant), 64'd1);
    chk("swap_to0_g1", 64'(m1_grant), 64'd0);

    // Master 1 read
    m0_req = 0;
    tick();
    chk("rd1_g1", 64'(m1_grant), 64'd1);
    m1_addr = 16'h7010; m1_wr = 0; bus_din = 64'h0000_0000_2222_2222;
    #1;
    chk("rd1_din1", m1_din, 64'h0000_0000_2222_2222);
    chk("rd1_din0", m0_din, 64'd0);
    chk("rd1_baddr", 64'(bus_addr), 64'h7010);
    chk("rd1_bwr", 64'(bus_wr), 64'd0);

    // Uncontested hold beyond saturation
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("solo1_c%0d", i), 64'(m1_grant), 64'd1);
    end
    m1_req = 0;
    tick();
    chk_idle_outputs("solo1_release");

    // Simultaneous drop and rise: direct handover
    m0_req = 1;
    tick();
    chk("hand_g0", 64'(m0_grant), 64'd1);
    m0_req = 0; m1_req = 1;
    tick();
    chk("hand_g1", 64'(m1_grant), 64'd1);
    chk("hand_g0_off", 64'(m0_grant), 64'd0);

    // Reset mid-grant with both requesting
    m0_req = 1;
    reset_n = 1'b1;
    tick();
    chk("midrst_g0", 64'(m0_grant), 64'd0);
    chk("midrst_g1", 64'(m1_grant), 64'd0);
    reset_n = 1'b0;
    tick();
    chk("postrst_g0", 64'(m0_grant), 64'd1);
    chk("postrst_g1", 64'(m1_grant), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
